// File: rtl/perf_uart_pkg.sv
// Shared types and constants for the performance-counter UART transmitter.
package perf_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS       = 8;
    localparam int UART_STOP_BITS       = 1;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/perf_byte_fifo.sv
// Byte FIFO buffering counter samples while a frame is on the wire.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module perf_byte_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               push_i,
    input  logic [7:0]         data_i,
    input  logic               pop_i,
    output logic [7:0]         data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [FIFO_AW:0]   count_o
);

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               wr_en;
    logic               rd_en;

    assign full_o  = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign rd_en   = pop_i & ~empty_o;
    assign wr_en   = push_i & (~full_o | rd_en);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/perf_uart_tx.sv
// 8N1 UART transmitter draining the performance-counter byte stream.
// Each rising edge of start_i queues one byte; bytes leave LSB-first on tx_o.
module perf_uart_tx
    import perf_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic [7:0]       data_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic [FIFO_AW:0] fifo_count_o,
    output logic             overflow_o
);

    localparam int STOP_CLKS = CLKS_PER_BIT * UART_STOP_BITS;
    localparam int TW        = clog2(STOP_CLKS);
    localparam int IW        = clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(STOP_CLKS - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

    uart_state_e         state_q;
    logic                tx_q;
    logic [TW-1:0]       timer_q;
    logic [IW-1:0]       idx_q;
    logic [7:0]          shift_q;
    logic                overflow_q;
    logic                start_prev_q;

    logic                push;
    logic                pop;
    logic [7:0]          fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_AW:0]    fifo_count;

    // A long start_i level produces a single request; start_prev resets high so a
    // level already present at reset release is ignored.
    assign push = start_i & ~start_prev_q;
    assign pop  = (state_q == ST_IDLE) & ~fifo_empty;

    perf_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .data_i  (data_i),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Frame sequencer: tx_q is loaded with the level of the state being entered.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            tx_q         <= 1'b1;
            timer_q      <= '0;
            idx_q        <= '0;
            overflow_q   <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            start_prev_q <= start_i;
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q <= fifo_rdata;
                        timer_q <= '0;
                        tx_q    <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q <= '0;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            shift_q <= shift_q >> 1;
                            idx_q   <= idx_q + IW'(1);
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (timer_q == STOP_LAST) begin
                        timer_q <= '0;
                        tx_q    <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_o         = tx_q;
    assign busy_o       = (state_q != ST_IDLE) | ~fifo_empty;
    assign fifo_count_o = fifo_count;
    assign overflow_o   = overflow_q;

endmodule

// File: doc/perf_uart_tx.md
Name: perf_uart_tx

Overview:
- 8N1 UART transmitter that drains the performance-counter byte stream (data byte plus start level, start held high for about one bit period) to the host link.
- Captures a byte on each rising edge of start_i and buffers it in a small FIFO, so back-to-back counter samples are not lost while a frame is on the wire.
- Serializes each byte LSB-first on tx_o.
- Sits between the cache-event counter and the board TX pin.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset
- start_i  in  1  byte-valid level; rising edge = one byte request
- data_i  in  8  byte to send, sampled on the start_i rising-edge cycle
- tx_o  out  1  serial line, idle high
- busy_o  out  1  frame in progress or FIFO non-empty
- fifo_count_o  out  FIFO_AW+1  bytes currently buffered
- overflow_o  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Clock and reset (already decided): reset rstn, synchronous, active-low; clock clk.
- Reset values: tx_o=1, busy_o=0, fifo_count_o=0, overflow_o=0; state=IDLE; bit timer=0; bit index=0; start_prev=1, so a start_i already high at reset release is not taken as an edge.
- Edge detect: start_prev<=start_i every cycle. push = start_i & ~start_prev. A level held high for any length gives exactly one push.
- FIFO push at edge k (push true): data_i is written and becomes visible at edge k.
- FIFO full with no pop in the same cycle: the byte is dropped, overflow_o<=1 and stays set until reset.
- Full FIFO with push and pop in the same cycle: both happen, count unchanged, no overflow.
- Pointers wrap modulo FIFO_DEPTH. Count is FIFO_AW+1 bits, range 0..FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If FIFO non-empty, pop head into shift register, timer<=0, go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles. At timer==CLKS_PER_BIT-1: timer<=0, idx<=0, go to DATA.
  - DATA: tx_o=shift[0] for CLKS_PER_BIT cycles per bit. At end of bit: shift right, idx+1. After idx==7 completes, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles, then return to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles of tx_o activity, plus one IDLE cycle between frames (the pop cycle).
- Latency: push at edge k; pop and START entry at edge k+1; tx_o low from edge k+1.
- tx_o is registered, no combinational path from inputs.
- busy_o = (state!=IDLE) | (count!=0), registered view consistent with state/count after each edge.
- data_i changing while start_i stays high has no effect; only the edge cycle is sampled.
- Reset mid-frame: on the next edge tx_o=1, FIFO emptied, state=IDLE, overflow_o cleared. A partial frame is truncated, not completed.

Decomposition:
- Shared package perf_uart_pkg:
  - state enum (IDLE/START/DATA/STOP)
  - UART_DATA_BITS=8, UART_STOP_BITS=1
  - default CLKS_PER_BIT=868
  - clog2 helper function
- One natural sub-module: perf_byte_fifo (synchronous, FIFO_DEPTH x 8, push/pop/full/empty/count, same-cycle push+pop when full allowed).
- The FSM and edge detector stay in perf_uart_tx.

Test Plan (CLKS_PER_BIT=8 for simulation):
- Single byte: start_i rises with data_i=0xA5, held 868 cycles -> tx_o low 8 cycles, then bits 1,0,1,0,0,1,0,1 (8 cycles each), stop high 8 cycles; exactly one frame, busy_o falls after stop, overflow_o=0.
- Latency: edge sampled at cycle k -> tx_o=0 from k+1, fifo_count_o 1 at k then 0 at k+1.
- Burst of 6 edges, 2 cycles apart, bytes 0x01..0x06 -> 0x01 popped immediately, 0x02..0x05 fill the FIFO (count=4), 0x06 dropped, overflow_o=1. tx_o carries frames 0x01..0x05 in order, each 80 cycles plus 1 IDLE cycle.
- Push on the exact pop cycle with FIFO full -> new byte accepted, count stays 4, overflow_o stays 0, all bytes transmitted.
- Reset mid-frame: rstn=0 during DATA bit 3 with 2 bytes queued -> next edge tx_o=1, count=0, busy_o=0, overflow_o=0. After release with start_i still high, no frame is sent.
- Start held high across reset release -> no push. A later low-then-high transition with data_i=0x3C -> one frame 0x3C.
